// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stalls, taken-branch flushes and data-memory wait stalls,
// with a memory-wait watchdog and saturating stall/flush cycle counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_bubble,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;
  logic             mw;
  logic             lu;
  logic             br;
  logic             rs_hit;
  logic             rt_hit;

  assign mw     = mem_req & ~mem_ready;
  assign br     = branch_taken;
  assign rs_hit = id_uses_rs & (id_rs == ex_rd);
  assign rt_hit = id_uses_rt & (id_rt == ex_rd);
  assign lu     = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) & (rs_hit | rt_hit);

  // Priority mw > br > lu: a memory wait freezes the whole front end, and a taken branch
  // makes the ID instruction wrong-path, so its load-use dependency is irrelevant.
  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path infers a latch.
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_bubble  = 1'b0;
    idex_stall   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    if (mw) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (br) begin
      ifid_bubble  = 1'b1;
      idex_bubble  = 1'b1;
    end else if (lu) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_bubble  = 1'b1;
    end
  end

  // Wait length including the current cycle; saturates so the watchdog compare stays true.
  always_comb begin
    wait_nxt = 1;
    if (state == MEM_WAIT)
      wait_nxt = (wait_cnt >= TIMEOUT) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (mw) begin
        state    <= MEM_WAIT;
        wait_cnt <= wait_nxt;
        if (wait_nxt == TIMEOUT)
          mem_timeout <= 1'b1;
      end else begin
        state    <= IDLE;
        wait_cnt <= '0;
      end
      if (pc_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (!mw && br && flush_count != '1)
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule
